// File: rtl/exc_check_requester.sv
// Requester side of the Data/Data_valid/ACK/Exc handshake for the FPU exception checker.
// Buffers words in a FIFO, issues them one at a time and returns {data, exc} results.
module exc_check_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Data,
  output logic        Data_valid,
  input  logic        ACK,
  input  logic [2:0]  Exc,
  output logic [31:0] res_data,
  output logic [2:0]  res_exc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [2:0]    EXC_TIMEOUT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_RESP
  } state_t;

  state_t         state;
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [TW-1:0]  tcnt;
  logic           push;
  logic           pop;

  // The checker leaves stale Exc on normal numbers; trust it only for exp==FF.
  function automatic logic [2:0] sanitize(
    input logic [31:0] d,
    input logic [2:0]  e
  );
    return (d[30:23] == 8'hFF) ? e : 3'b000;
  endfunction

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && (count != '0) && !res_valid;
  assign busy     = (state != S_IDLE) || (count != '0);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      Data       <= '0;
      Data_valid <= 1'b0;
      tcnt       <= '0;
      res_data   <= '0;
      res_exc    <= '0;
      res_valid  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            Data       <= mem[rd_ptr];
            Data_valid <= 1'b1;
            tcnt       <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (ACK) begin
            res_exc    <= sanitize(Data, Exc);
            res_data   <= Data;
            Data_valid <= 1'b0;
            state      <= S_REL;
          end else if (tcnt == TMAX) begin
            res_exc    <= EXC_TIMEOUT;
            res_data   <= Data;
            Data_valid <= 1'b0;
            state      <= S_REL;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        // One quiet cycle lets the checker fall back to compute.
        S_REL: begin
          res_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_check_requester.sv
// Directed bench for exc_check_requester with immediate-assertion checks.
// Expected values are hand-computed per step.
module tb_exc_check_requester;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        CLK;
  logic        RSTN;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Data;
  logic        Data_valid;
  logic        ACK;
  logic [2:0]  Exc;
  logic [31:0] res_data;
  logic [2:0]  res_exc;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  exc_check_requester #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Data       (Data),
    .Data_valid (Data_valid),
    .ACK        (ACK),
    .Exc        (Exc),
    .res_data   (res_data),
    .res_exc    (res_exc),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input int lim);
    int n = 0;
    while (Data_valid !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("wait_data_valid", {31'd0, Data_valid}, 32'd1);
  endtask

  task automatic wait_rv(input int lim);
    int n = 0;
    while (res_valid !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    chk("wait_res_valid", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    step();
    in_valid = 1'b0;
  endtask

  // Acknowledge the current request with code e, expect {d, x} back.
  task automatic serve(input logic [2:0] e, input logic [31:0] d,
                       input logic [2:0] x);
    wait_dv(40);
    chk("req_data", Data, d);
    ACK = 1'b1;
    Exc = e;
    step();
    ACK = 1'b0;
    Exc = 3'b000;
    chk("dv_drop", {31'd0, Data_valid}, 32'd0);
    wait_rv(10);
    chk("res_data", res_data, d);
    chk("res_exc", {29'd0, res_exc}, {29'd0, x});
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("rv_clear", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    RSTN      = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    ACK       = 1'b0;
    Exc       = 3'b000;
    res_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_dv", {31'd0, Data_valid}, 32'd0);
    chk("rst_data", Data, 32'd0);
    chk("rst_rv", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_exc", {29'd0, res_exc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    RSTN = 1'b1;
    step();

    // 1: infinity, ACK one cycle late, extra ACK in RELEASE ignored
    push(32'h7F80_0000);
    chk("t1_dv_lat1", {31'd0, Data_valid}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t1_dv_lat2", {31'd0, Data_valid}, 32'd1);
    chk("t1_data", Data, 32'h7F80_0000);
    step();
    chk("t1_dv_hold", {31'd0, Data_valid}, 32'd1);
    ACK = 1'b1;
    Exc = 3'b011;
    step();
    Exc = 3'b100;
    chk("t1_dv_low", {31'd0, Data_valid}, 32'd0);
    chk("t1_rv_early", {31'd0, res_valid}, 32'd0);
    step();
    ACK = 1'b0;
    Exc = 3'b000;
    chk("t1_rv", {31'd0, res_valid}, 32'd1);
    chk("t1_res_data", res_data, 32'h7F80_0000);
    chk("t1_res_exc", {29'd0, res_exc}, 32'd3);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t1_rv_clear", {31'd0, res_valid}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: NaN then normal, checker says NaN for both
    push(32'h7FC0_0000);
    push(32'h3F80_0000);
    serve(3'b100, 32'h7FC0_0000, 3'b100);
    serve(3'b100, 32'h3F80_0000, 3'b000);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // 3: fill FIFO behind a stalled request
    in_valid = 1'b1;
    in_data = 32'h3F80_0000; step();
    in_data = 32'h7F80_0000; step();
    in_data = 32'h4000_0000; step();
    in_data = 32'h7FC0_0001; step();
    in_data = 32'h0000_0000; step();
    in_data = 32'hFF80_0000;
    chk("t3_full", {31'd0, in_ready}, 32'd0);
    step();
    step();
    chk("t3_still_full", {31'd0, in_ready}, 32'd0);
    chk("t3_head", Data, 32'h3F80_0000);
    ACK = 1'b1;
    Exc = 3'b100;
    step();
    ACK = 1'b0;
    step();
    chk("t3_rv0", {31'd0, res_valid}, 32'd1);
    chk("t3_rd0", res_data, 32'h3F80_0000);
    chk("t3_re0", {29'd0, res_exc}, 32'd0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t3_full_idle", {31'd0, in_ready}, 32'd0);
    step();
    chk("t3_pop_ready", {31'd0, in_ready}, 32'd1);
    chk("t3_pop_data", Data, 32'h7F80_0000);
    step();
    in_valid = 1'b0;
    chk("t3_refull", {31'd0, in_ready}, 32'd0);
    serve(3'b011, 32'h7F80_0000, 3'b011);
    serve(3'b011, 32'h4000_0000, 3'b000);
    serve(3'b100, 32'h7FC0_0001, 3'b100);
    serve(3'b100, 32'h0000_0000, 3'b000);
    serve(3'b011, 32'hFF80_0000, 3'b011);
    chk("t3_idle", {31'd0, busy}, 32'd0);

    // 4: timeout on -inf, next word proceeds
    push(32'hFF80_0000);
    push(32'h3F80_0000);
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
    end
    chk("t4_dv_hold", {31'd0, Data_valid}, 32'd1);
    chk("t4_data", Data, 32'hFF80_0000);
    step();
    chk("t4_dv_low", {31'd0, Data_valid}, 32'd0);
    step();
    chk("t4_rv", {31'd0, res_valid}, 32'd1);
    chk("t4_res_exc", {29'd0, res_exc}, 32'd7);
    chk("t4_res_data", res_data, 32'hFF80_0000);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    serve(3'b011, 32'h3F80_0000, 3'b000);

    // 5: result back-pressure, stray ACKs while waiting
    push(32'h7F80_0000);
    push(32'h7FC0_0000);
    push(32'h3F80_0000);
    push(32'hFF80_0000);
    ACK = 1'b1;
    Exc = 3'b011;
    step();
    ACK = 1'b0;
    step();
    ACK = 1'b1;
    Exc = 3'b100;
    for (int i = 0; i < 10; i++) begin
      chk("t5_rv", {31'd0, res_valid}, 32'd1);
      chk("t5_rd", res_data, 32'h7F80_0000);
      chk("t5_re", {29'd0, res_exc}, 32'd3);
      chk("t5_no_req", {31'd0, Data_valid}, 32'd0);
      step();
    end
    ACK = 1'b0;
    Exc = 3'b000;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    serve(3'b100, 32'h7FC0_0000, 3'b100);
    serve(3'b100, 32'h3F80_0000, 3'b000);
    serve(3'b011, 32'hFF80_0000, 3'b011);

    // 6: reset while requesting with two words queued
    push(32'h7F80_0000);
    push(32'h7FC0_0000);
    push(32'h3F80_0000);
    chk("t6_in_req", {31'd0, Data_valid}, 32'd1);
    RSTN = 1'b0;
    #1;
    chk("t6_dv", {31'd0, Data_valid}, 32'd0);
    chk("t6_data", Data, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_rv", {31'd0, res_valid}, 32'd0);
    step();
    RSTN = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_quiet_dv", {31'd0, Data_valid}, 32'd0);
      chk("t6_quiet_rv", {31'd0, res_valid}, 32'd0);
    end
    res_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_check_requester.md
Name: exc_check_requester

Overview:
Initiator side of the Data/Data_valid/ACK/Exc handshake used by the FPU exception checker. It accepts IEEE-754 single-precision words from an upstream valid/ready stream and buffers them in a small FIFO. It issues one word at a time to the checker, waits for the ACK pulse, captures the Exc classification, and returns {data, exc} on a downstream valid/ready result stream. A timeout counter guards against a checker that never acknowledges.

Parameters:
DEPTH, 4, input FIFO entries (power of two, >=2)
TIMEOUT, 16, max cycles REQ may wait for ACK before a timeout is reported (>=2)

Ports:
CLK  input  1  clock, all logic on posedge
RSTN  input  1  asynchronous active-low reset
in_data  input  32  operand word from upstream
in_valid  input  1  upstream word valid
in_ready  output  1  FIFO not full
Data  output  32  word presented to checker
Data_valid  output  1  request strobe to checker
ACK  input  1  checker acknowledge (one-cycle pulse)
Exc  input  3  checker classification, valid while ACK=1
res_data  output  32  word that was checked
res_exc  output  3  final classification
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
busy  output  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (async, RSTN=0): FIFO empty, pointers and count 0, state IDLE, Data=0, Data_valid=0, res_valid=0, res_data=0, res_exc=0, timeout counter 0, busy=0; in_ready=1 after reset. Reset mid-transaction discards all queued and in-flight words; no result is emitted for them.
- FIFO: push when in_valid&&in_ready; pop only on the IDLE->REQ transition. in_ready = (count!=DEPTH). Simultaneous push and pop at full is not allowed: in_ready is already 0. Simultaneous push and pop at other levels leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty and res_valid=0, pop the head into Data, set Data_valid=1, clear the timeout counter, go to REQ. Registered, so the first request cycle follows the pop edge.
  - REQ: hold Data_valid=1 and Data stable.
    - ACK=1 at a posedge: capture Exc into res_exc, Data into res_data, set Data_valid=0, go to RELEASE.
    - Otherwise increment the counter. At count==TIMEOUT-1 without ACK: res_exc=3'b111, res_data=Data, Data_valid=0, go to RELEASE.
  - RELEASE: wait one cycle with Data_valid=0 so the checker returns to its compute state. Any ACK seen here is ignored. Set res_valid=1, go to RESP.
  - RESP: hold res_valid, res_data and res_exc until res_valid&&res_ready, then res_valid=0 and go to IDLE.
- Classification sanitising, applied at capture:
  - If Data[30:23]!=8'hFF, res_exc=3'b000 regardless of Exc, because the checker holds stale Exc for normal numbers.
  - If exponent==8'hFF, res_exc=Exc as sampled.
  - The timeout code 3'b111 overrides both rules.
- Exc codes: 000 none, 011 infinity, 100 NaN, 111 timeout (requester-generated).
- Latency: an empty-FIFO push at cycle t gives Data_valid=1 at t+2. With an immediate ACK in REQ, res_valid=1 at t+4. Back-to-back throughput is one word per 4 cycles with res_ready held at 1.
- ACK outside REQ never changes state or results.
- busy = (state!=IDLE) || (count!=0).

Test Plan:
1. Push 32'h7F800000, ACK one cycle after Data_valid with Exc=011 -> res_data=7F800000, res_exc=011, res_valid rises 2 cycles after ACK, Data_valid low the cycle after ACK.
2. Push 32'h7FC00000 then 32'h3F800000, with the checker returning Exc=100 for both -> results in order: 7FC00000/100, then 3F800000/000 (sanitised).
3. Push DEPTH+1 words with ACK withheld -> in_ready=0 once count==DEPTH. The extra word is not accepted until the first pop, and no word is lost or duplicated.
4. Never assert ACK for word 32'hFF800000 -> after TIMEOUT cycles in REQ, res_exc=111, res_data=FF800000; the next queued word then issues normally.
5. Hold res_ready=0 for 10 cycles with 3 words queued -> res_valid/res_data stable, no new Data_valid until the handshake; then the remaining words drain in order.
6. Assert RSTN=0 while in REQ with 2 words queued -> all outputs return to reset values immediately, and no result is emitted after release.
